ex_result_buffer: RTL and testbench
===================================

// Module: ex_result_buffer
// PURPOSE
//  Execute-stage back end, directly downstream of the barrel shifter. Selects the shifter result H or ALU result G
//  (function-select MF), derives N/Z/C/V status, and queues result + writeback control in a small FIFO
//  toward the writeback stage. Uses a valid/ready handshake on both sides so a WB stall never corrupts
//  an in-flight result. Supports pipeline flush on branch/exception.
// PARAMETERS
//  WIDTH   32  datapath width of G, H and F
//  DEPTH   2   FIFO entries; power of two, >= 2
//  AW      5   destination-register address width
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  flush      in   1      discard all buffered and incoming entries
//  in_valid   in   1      execute stage presents a result
//  in_ready   out  1      buffer can accept (registered; = !full)
//  G          in   WIDTH  ALU result
//  H          in   WIDTH  barrel shifter result
//  MF         in   1      1: F=H, 0: F=G
//  c_in       in   1      ALU carry-out
//  v_in       in   1      ALU overflow
//  DA         in   AW     destination register
//  RW         in   1      register-write enable
//  out_valid  out  1      head entry valid toward WB
//  out_ready  in   1      WB consumes head
//  F          out  WIDTH  selected result (head)
//  out_DA     out  AW     head destination register
//  out_RW     out  1      head register-write enable
//  N,Z,C,V    out  1 ea   head status flags
// BEHAVIOUR
//  - Reset (rst=1 at edge): count=0, pointers=0; out_valid, F, out_DA, out_RW, N, Z, C, V all 0;
//    in_ready=0 during the reset cycle, 1 the first cycle after rst deasserts.
//  - push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
//  - Entry written on push: F=MF?H:G; N=F[WIDTH-1]; Z=(F==0); C=MF?0:c_in; V=MF?0:v_in;
//    DA and RW copied unchanged.
//  - Latency: entry pushed at edge k into empty buffer is visible with out_valid=1 after edge k (cycle k+1).
//  - Outputs are the head entry driven from registers; they hold stable while out_valid & !out_ready.
//  - When out_valid=0, F/out_DA/out_RW/flags hold their last values; WB must ignore them.
//  - count update: push&!pop -> +1; pop&!push -> -1; push&pop -> unchanged (data passes through).
//  - in_ready = (count < DEPTH), registered from the next-count value; never combinational from out_ready.
//    When full, a same-cycle pop does NOT enable a push that cycle.
//  - Read/write pointers wrap modulo DEPTH; no wrap arithmetic exposed on ports.
//  - flush: at the edge, count=0 and pointers=0; out_valid=0 the next cycle; the same-cycle input
//    and any same-cycle pop are discarded (WB must not commit on a flush cycle). in_ready=1 after flush.
//  - rst has priority over flush; flush has priority over push/pop.
//  - No overflow/underflow: push never occurs when full, pop never when empty.
// TESTING
//  1 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=0; in_ready=1 after release.
//  2 Select/flags: MF=1,H=0x8000_0000,G=5,c_in=1 -> F=0x8000_0000,N=1,Z=0,C=0,V=0; MF=0,G=0,c_in=1,v_in=1 -> F=0,Z=1,C=1,V=1.
//  3 Backpressure: out_ready=0, push A,B -> in_ready=0 after second push; C held off; release -> A,B,C in order, none lost/duplicated.
//  4 Pass-through: count=1, push and pop same cycle for 10 cycles -> count stays 1, out_valid continuous, order preserved.
//  5 Flush: buffer full + in_valid=1 + flush=1 -> next cycle out_valid=0, in_ready=1; incoming entry never appears.
//  6 Reset mid-stream: rst asserted with 2 entries queued and out_ready=1 -> no pop reported after reset, buffer empty.

Source files
------------

// File: rtl/ex_result_buffer.sv
// Execute-stage result buffer: F select, N/Z/C/V flags,
// and a small valid/ready FIFO toward writeback.
module ex_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic             MF,
  input  logic             c_in,
  input  logic             v_in,
  input  logic [AW-1:0]    DA,
  input  logic             RW,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [AW-1:0]    out_DA,
  output logic             out_RW,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = WIDTH + AW + 5;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [EW-1:0] head_q;
  logic [EW-1:0] head_nxt;
  logic [EW-1:0] new_entry;
  logic [WIDTH-1:0] sel_f;
  logic push;
  logic pop;

  // Build the entry to store: selected result, flags, WB control.
  always_comb begin
    sel_f = MF ? H : G;
    new_entry = {
      sel_f,
      DA,
      RW,
      sel_f[WIDTH-1],
      (sel_f == '0),
      MF ? 1'b0 : c_in,
      MF ? 1'b0 : v_in
    };
  end

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Next occupancy, next read pointer and next head entry.
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    rd_nxt = rd_ptr + PW'(pop);
    // Head location being written this edge: take the new entry.
    if (push && (rd_nxt == wr_ptr))
      head_nxt = new_entry;
    else
      head_nxt = mem[rd_nxt];
  end

  // Storage array write on accepted input.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= new_entry;
  end

  // Pointers, occupancy and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      in_ready  <= (count_nxt < CW'(DEPTH));
    end
  end

  // Head output register; holds when empty or stalled.
  always_ff @(posedge clk) begin
    if (rst)
      head_q <= '0;
    else if (!flush && (push || pop) && (count_nxt != '0))
      head_q <= head_nxt;
  end

  assign {F, out_DA, out_RW, N, Z, C, V} = head_q;

endmodule

// File: tb/tb_ex_result_buffer.sv
// Scoreboard bench for ex_result_buffer.
// Expected entries are queued on accept, checked on pop.
module tb_ex_result_buffer;

  localparam int EW = 32 + 5 + 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] G = '0;
  logic [31:0] H = '0;
  logic        MF = 1'b0;
  logic        c_in = 1'b0;
  logic        v_in = 1'b0;
  logic [4:0]  DA = '0;
  logic        RW = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] F;
  logic [4:0]  out_DA;
  logic        out_RW;
  logic        N, Z, C, V;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] sb[$];

  ex_result_buffer #(.WIDTH(32), .DEPTH(2), .AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .G(G), .H(H), .MF(MF), .c_in(c_in), .v_in(v_in),
    .DA(DA), .RW(RW),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .out_DA(out_DA), .out_RW(out_RW),
    .N(N), .Z(Z), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] model(
    input logic mf, input logic [31:0] g,
    input logic [31:0] h, input logic c,
    input logic v, input logic [4:0] da,
    input logic rw);
    logic [31:0] f;
    f = mf ? h : g;
    return {f, da, rw, f[31], (f == 32'd0),
            mf ? 1'b0 : c, mf ? 1'b0 : v};
  endfunction

  // Scoreboard monitor, sampled mid-cycle before the edge.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected F=%h DA=%0d", F, out_DA);
        end else begin
          logic [EW-1:0] exp;
          exp = sb.pop_front();
          if ({F, out_DA, out_RW, N, Z, C, V} !== exp) begin
            errors++;
            $display("FAIL pop_data got=%h exp=%h",
              {F, out_DA, out_RW, N, Z, C, V}, exp);
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(MF, G, H, c_in, v_in, DA, RW));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mf, input logic [31:0] g,
                       input logic [31:0] h, input logic c,
                       input logic v, input logic [4:0] da,
                       input logic rw);
    in_valid = 1'b1;
    MF = mf; G = g; H = h;
    c_in = c; v_in = v; DA = da; RW = rw;
  endtask

  task automatic drive_rand();
    drive(1'($urandom), $urandom, $urandom, 1'($urandom),
          1'($urandom), 5'($urandom), 1'($urandom));
  endtask

  // Hold in_valid until accepted, bounded.
  task automatic push_wait(input string name);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      step();
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s accept_timeout in_ready=%b", name, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++)
      step();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s drain left=%0d out_valid=%b exp 0/0",
        name, sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h1234, 32'h5678, 1'b1, 1'b1, 5'd7, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({out_valid, in_ready, F, out_DA, out_RW, N, Z, C, V}
          !== '0) begin
        errors++;
        $display("FAIL reset_outputs ov=%b ir=%b F=%h DA=%0d",
          out_valid, in_ready, F, out_DA);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ir=%b ov=%b exp 1/0",
        in_ready, out_valid);
    end
  endtask

  task automatic test_select();
    out_ready = 1'b1;
    drive(1'b1, 32'd5, 32'h8000_0000, 1'b1, 1'b1, 5'd3, 1'b1);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, F, N, Z, C, V} !==
        {1'b1, 32'h8000_0000, 4'b1000}) begin
      errors++;
      $display("FAIL select_shift ov=%b F=%h NZCV=%b%b%b%b",
        out_valid, F, N, Z, C, V);
    end
    drive(1'b0, 32'd0, 32'd7, 1'b1, 1'b1, 5'd9, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, F, N, Z, C, V} !==
        {1'b1, 32'd0, 4'b0111}) begin
      errors++;
      $display("FAIL select_alu ov=%b F=%h NZCV=%b%b%b%b",
        out_valid, F, N, Z, C, V);
    end
    drain("select");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b0, 32'hA, 32'h0, 1'b0, 1'b0, 5'd1, 1'b1);
    step();
    drive(1'b0, 32'hB, 32'h0, 1'b1, 1'b0, 5'd2, 1'b1);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full ir=%b ov=%b exp 0/1",
        in_ready, out_valid);
    end
    drive(1'b1, 32'h0, 32'hC, 1'b0, 1'b0, 5'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || F !== 32'hA) begin
        errors++;
        $display("FAIL bp_hold ir=%b F=%h exp 0/0000000a",
          in_ready, F);
      end
    end
    out_ready = 1'b1;
    push_wait("bp_c");
    drain("backpressure");
  endtask

  task automatic test_pass_through();
    out_ready = 1'b0;
    drive_rand();
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand();
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL pass_through i=%0d ov=%b ir=%b exp 1/1",
          i, out_valid, in_ready);
      end
    end
    drain("pass_through");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_rand();
    step();
    drive_rand();
    step();
    drive(1'b0, 32'hDEAD, 32'h0, 1'b0, 1'b0, 5'd30, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state ov=%b ir=%b exp 0/1",
        out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost ov=%b F=%h exp 0",
          out_valid, F);
      end
    end
    drain("flush");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_rand();
    step();
    drive_rand();
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || F !== '0) begin
      errors++;
      $display("FAIL rst_mid ov=%b ir=%b F=%h exp 0/0/0",
        out_valid, in_ready, F);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_ghost ov=%b exp 0", out_valid);
      end
    end
    drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++) begin
      drive_rand();
      for (int i = 0; i < 40; i++) begin
        logic acc;
        acc = in_ready;
        out_ready = 1'($urandom);
        step();
        if (acc) break;
      end
      in_valid = 1'b0;
    end
    drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_pass_through();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
